// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master and its users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4lite_pkg;

    // Default geometry; the master itself is parameterised and may differ.
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ADDR_W = 11;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    // BRESP / RRESP encodings.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } axi_master_state_t;

    // Command and response records for the default 32/11 configuration.
    typedef struct packed {
        logic                  write;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_DATA_W-1:0] wdata;
        logic [AXI_STRB_W-1:0] wstrb;
    } cmd_t;

    typedef struct packed {
        logic                  write;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            resp;
    } rsp_t;

endpackage

// File: rtl/axi4lite_timeout_ctr.sv
// Saturating wait counter: pulses expire once when LIMIT cycles have been counted.
// Latency: expire is combinational in the cycle that completes the LIMIT-th count.
// Backpressure: none; restart has priority and suppresses expire in that cycle.
//
// Ports: clk/rst_n clock and async active-low reset; restart zeroes the count;
// count_en advances it; expire is the one-shot expiry pulse. LIMIT=0 disables.
module axi4lite_timeout_ctr #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic count_en,
    output logic expire
);

    localparam int            CW      = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
    localparam logic [CW-1:0] LAST_C  = (LIMIT < 1) ? '0 : CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else if (count_en && (cnt_q != LIMIT_C)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A handshake in the last allowed cycle (restart) is still in time.
    assign expire = (LIMIT != 0) && count_en && !restart && (cnt_q == LAST_C);

endmodule

// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: command stream in, AXI transaction, response stream out.
// Latency: accept c0, AW/W c1, B c2, rsp_valid c3 with a zero-wait slave; reads likewise via AR/R.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready; slave stalls only raise timeout_flag.
//
// Ports: cmd_* command stream (valid/ready), rsp_* completion stream (valid/ready),
// timeout_flag/timeout_clr sticky stall indicator, M_AXI_* AXI4-Lite master interface.
module axi4lite_cmd_master
    import axi4lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 11,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,

    output logic                              timeout_flag,
    input  logic                              timeout_clr,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW         = C_M_AXI_ADDR_WIDTH;
    localparam int ALIGN_BITS = $clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam logic [AW-1:0] ADDR_MASK = ~AW'((1 << ALIGN_BITS) - 1);

    axi_master_state_t state_q, state_d;

    logic [AW-1:0]                     addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic                              awvalid_q, wvalid_q, arvalid_q;
    logic                              aw_done, w_done;
    logic                              to_expire, to_count;

    // A channel is done once its valid has dropped or it handshakes this cycle.
    assign aw_done = !awvalid_q || M_AXI_AWREADY;
    assign w_done  = !wvalid_q  || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (cmd_valid) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
            WR_ADDR_DATA: if (aw_done && w_done) state_d = WR_RESP;
            WR_RESP:      if (M_AXI_BVALID) state_d = RESP;
            RD_ADDR:      if (M_AXI_ARREADY) state_d = RD_DATA;
            RD_DATA:      if (M_AXI_RVALID) state_d = RESP;
            RESP:         if (rsp_ready) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Valids are registered so none of them depends combinationally on a ready.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr & ADDR_MASK;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        awvalid_q <= cmd_write;
                        wvalid_q  <= cmd_write;
                        arvalid_q <= !cmd_write;
                    end
                end
                WR_ADDR_DATA: begin
                    if (M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        rsp_resp  <= M_AXI_BRESP;
                        rsp_rdata <= '0;
                        rsp_write <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) arvalid_q <= 1'b0;
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rsp_resp  <= M_AXI_RRESP;
                        rsp_rdata <= M_AXI_RDATA;
                        rsp_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Count only while waiting on the slave; every state change restarts the count.
    assign to_count = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                      (state_q == RD_ADDR)      || (state_q == RD_DATA);

    axi4lite_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (M_AXI_ACLK),
        .rst_n    (M_AXI_ARESETN),
        .restart  (state_d != state_q),
        .count_en (to_count),
        .expire   (to_expire)
    );

    // Set wins over a simultaneous clear.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            timeout_flag <= 1'b0;
        end else if (to_expire) begin
            timeout_flag <= 1'b1;
        end else if (timeout_clr) begin
            timeout_flag <= 1'b0;
        end
    end

    // Gate with reset so nothing is offered as accepted while reset is held.
    assign cmd_ready     = (state_q == IDLE) && M_AXI_ARESETN;
    assign rsp_valid     = (state_q == RESP);

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed bench for axi4lite_cmd_master: a vector table drives a small configurable
// slave, plus hand-written sequences for timeout clear and reset mid-transaction.
// All sampling and driving happens on the falling clock edge.
module tb_axi4lite_cmd_master;
    import axi4lite_pkg::*;

    logic        M_AXI_ACLK = 1'b0;
    logic        M_AXI_ARESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [10:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_flag, timeout_clr;
    logic [10:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    int n_cmp = 0;
    int n_err = 0;

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    axi4lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (11),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .M_AXI_ACLK    (M_AXI_ACLK),
        .M_AXI_ARESETN (M_AXI_ARESETN),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .timeout_flag  (timeout_flag),
        .timeout_clr   (timeout_clr),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    // One transaction: command, slave wait states, expected AXI address/response,
    // expected rsp_valid cycle (command accepted in cycle 0), response hold cycles,
    // and the first cycle timeout_flag must read 1 (0 = never).
    typedef struct {
        logic        write;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          resp_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [10:0] exp_addr;
        int          exp_rsp_cyc;
        int          rsp_hold;
        int          exp_to_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0;
        bit aw_d = 0, w_d = 0, ar_d = 0, b_d = 0, r_d = 0, rsp_seen = 0, done = 0;
        int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0, hold = 0;
        int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_cyc = 0, r_cyc = 0, b_hs = 0, r_hs = 0;
        logic [31:0] exp_rdata;
        exp_rdata = v.write ? 32'h0 : v.rdata;

        chk($sformatf("v%0d_cmd_ready_idle", idx), 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.wstrb;
        @(negedge M_AXI_ACLK);
        cyc = 1;
        // Keep a junk command on the bus; it must be ignored while busy.
        cmd_write = ~v.write;
        cmd_addr  = 11'h555;
        cmd_wdata = 32'hFFFF_FFFF;
        cmd_wstrb = 4'h0;

        while (!done && cyc < 200) begin
            if (aw_d) M_AXI_AWREADY = 1'b0;
            if (w_d)  M_AXI_WREADY  = 1'b0;
            if (ar_d) M_AXI_ARREADY = 1'b0;
            if (b_d)  M_AXI_BVALID  = 1'b0;
            if (r_d)  M_AXI_RVALID  = 1'b0;

            if (aw_d && cyc == aw_cyc + 1) chk($sformatf("v%0d_awvalid_drop", idx), 32'(M_AXI_AWVALID), 32'(0));
            if (w_d && cyc == w_cyc + 1) begin
                chk($sformatf("v%0d_wvalid_drop", idx), 32'(M_AXI_WVALID), 32'(0));
                if (!aw_d) chk($sformatf("v%0d_awvalid_held", idx), 32'(M_AXI_AWVALID), 32'(1));
            end
            if (ar_d && cyc == ar_cyc + 1) chk($sformatf("v%0d_arvalid_drop", idx), 32'(M_AXI_ARVALID), 32'(0));
            if (b_d && cyc == b_cyc + 1) chk($sformatf("v%0d_bready_drop", idx), 32'(M_AXI_BREADY), 32'(0));
            if (r_d && cyc == r_cyc + 1) chk($sformatf("v%0d_rready_drop", idx), 32'(M_AXI_RREADY), 32'(0));

            chk($sformatf("v%0d_timeout_flag_c%0d", idx, cyc), 32'(timeout_flag),
                32'(v.exp_to_cyc != 0 && cyc >= v.exp_to_cyc));
            if (v.write)
                chk($sformatf("v%0d_no_read_chan", idx), 32'(M_AXI_ARVALID | M_AXI_RREADY), 32'(0));
            else
                chk($sformatf("v%0d_no_write_chan", idx),
                    32'(M_AXI_AWVALID | M_AXI_WVALID | M_AXI_BREADY), 32'(0));

            // Slave: ready after the configured number of cycles with valid high.
            if (!aw_d && M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_c >= v.aw_dly); aw_c++; end
            if (!w_d  && M_AXI_WVALID)  begin M_AXI_WREADY  = (w_c  >= v.w_dly);  w_c++;  end
            if (!ar_d && M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_c >= v.ar_dly); ar_c++; end
            if (!b_d && M_AXI_BREADY) begin
                if (b_c >= v.resp_dly) begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = v.resp; end
                b_c++;
            end
            if (!r_d && M_AXI_RREADY) begin
                if (r_c >= v.resp_dly) begin
                    M_AXI_RVALID = 1'b1; M_AXI_RRESP = v.resp; M_AXI_RDATA = v.rdata;
                end
                r_c++;
            end

            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_d = 1; aw_cyc = cyc;
                chk($sformatf("v%0d_awaddr", idx), 32'(M_AXI_AWADDR), 32'(v.exp_addr));
                chk($sformatf("v%0d_awprot", idx), 32'(M_AXI_AWPROT), 32'(0));
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_d = 1; w_cyc = cyc;
                chk($sformatf("v%0d_wdata", idx), M_AXI_WDATA, v.wdata);
                chk($sformatf("v%0d_wstrb", idx), 32'(M_AXI_WSTRB), 32'(v.wstrb));
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                ar_d = 1; ar_cyc = cyc;
                chk($sformatf("v%0d_araddr", idx), 32'(M_AXI_ARADDR), 32'(v.exp_addr));
                chk($sformatf("v%0d_arprot", idx), 32'(M_AXI_ARPROT), 32'(0));
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin b_d = 1; b_cyc = cyc; b_hs++; end
            if (M_AXI_RVALID && M_AXI_RREADY) begin r_d = 1; r_cyc = cyc; r_hs++; end

            if (rsp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen = 1;
                    chk($sformatf("v%0d_rsp_cycle", idx), 32'(cyc), 32'(v.exp_rsp_cyc));
                end
                chk($sformatf("v%0d_rsp_write", idx), 32'(rsp_write), 32'(v.write));
                chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, exp_rdata);
                chk($sformatf("v%0d_rsp_resp", idx), 32'(rsp_resp), 32'(v.resp));
                chk($sformatf("v%0d_cmd_ready_busy", idx), 32'(cmd_ready), 32'(0));
                if (hold < v.rsp_hold) begin
                    rsp_ready = 1'b0;
                    hold++;
                end else begin
                    rsp_ready = 1'b1;
                    cmd_valid = 1'b0;
                    done = 1;
                end
            end else begin
                rsp_ready = 1'b0;
            end

            @(negedge M_AXI_ACLK);
            cyc++;
        end

        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_completed", idx), 32'(done), 32'(1));
        if (v.write) chk($sformatf("v%0d_b_count", idx), 32'(b_hs), 32'(1));
        else         chk($sformatf("v%0d_r_count", idx), 32'(r_hs), 32'(1));
        chk($sformatf("v%0d_rsp_valid_after", idx), 32'(rsp_valid), 32'(0));
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID  = 1'b0; M_AXI_RVALID = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        M_AXI_ARESETN = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; timeout_clr = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;

        //            wr    addr     wdata         strb aw w  ar rsp resp         rdata          exp_addr rsp hold to
        vecs[0] = '{1'b1, 11'h008, 32'hDEADBEEF, 4'hF, 0, 0, 0,  0, RESP_OKAY,   32'h0,         11'h008, 3,  0, 0};
        vecs[1] = '{1'b0, 11'h00D, 32'h0,        4'h0, 0, 0, 0,  4, RESP_OKAY,   32'h12345678,  11'h00C, 7,  0, 0};
        vecs[2] = '{1'b1, 11'h013, 32'hA5A50F0F, 4'h5, 3, 0, 0,  1, RESP_SLVERR, 32'h0,         11'h010, 7,  0, 0};
        vecs[3] = '{1'b1, 11'h7FF, 32'h01020304, 4'h8, 0, 2, 0,  0, RESP_OKAY,   32'h0,         11'h7FC, 5,  0, 0};
        vecs[4] = '{1'b0, 11'h404, 32'h0,        4'h0, 0, 0, 2,  0, RESP_DECERR, 32'hCAFEF00D,  11'h404, 5,  5, 0};
        vecs[5] = '{1'b1, 11'h100, 32'hFFFF0000, 4'hC, 2, 2, 0,  0, RESP_EXOKAY, 32'h0,         11'h100, 5,  0, 0};
        vecs[6] = '{1'b0, 11'h020, 32'h0,        4'h0, 0, 0, 20, 0, RESP_OKAY,   32'h0BADCAFE,  11'h020, 23, 0, 17};

        // Reset state.
        repeat (3) @(negedge M_AXI_ACLK);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        M_AXI_ARESETN = 1'b1;
        @(negedge M_AXI_ACLK);
        chk("rst_awvalid", 32'(M_AXI_AWVALID), 32'(0));
        chk("rst_wvalid", 32'(M_AXI_WVALID), 32'(0));
        chk("rst_arvalid", 32'(M_AXI_ARVALID), 32'(0));
        chk("rst_bready", 32'(M_AXI_BREADY), 32'(0));
        chk("rst_rready", 32'(M_AXI_RREADY), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_timeout_flag", 32'(timeout_flag), 32'(0));
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_resp", 32'(rsp_resp), 32'(0));
        chk("rst_rsp_write", 32'(rsp_write), 32'(0));
        chk("rst_awaddr", 32'(M_AXI_AWADDR), 32'(0));
        chk("rst_araddr", 32'(M_AXI_ARADDR), 32'(0));

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Flag is sticky until cleared.
        repeat (2) @(negedge M_AXI_ACLK);
        chk("to_sticky", 32'(timeout_flag), 32'(1));
        timeout_clr = 1'b1;
        @(negedge M_AXI_ACLK);
        timeout_clr = 1'b0;
        chk("to_cleared", 32'(timeout_flag), 32'(0));

        // Reset while waiting for B.
        chk("rs_cmd_ready", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h040;
        cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        @(negedge M_AXI_ACLK);
        cmd_valid = 1'b0;
        chk("rs_awvalid", 32'(M_AXI_AWVALID), 32'(1));
        chk("rs_wvalid", 32'(M_AXI_WVALID), 32'(1));
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        @(negedge M_AXI_ACLK);
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        chk("rs_bready_before", 32'(M_AXI_BREADY), 32'(1));
        M_AXI_ARESETN = 1'b0;
        #1;
        chk("rs_async_bready", 32'(M_AXI_BREADY), 32'(0));
        chk("rs_async_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_RREADY}), 32'(0));
        chk("rs_async_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rs_async_cmd_ready", 32'(cmd_ready), 32'(0));
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = RESP_SLVERR;
        repeat (2) @(negedge M_AXI_ACLK);
        M_AXI_ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge M_AXI_ACLK);
            chk($sformatf("rs_post_cmd_ready_%0d", i), 32'(cmd_ready), 32'(1));
            chk($sformatf("rs_post_rsp_valid_%0d", i), 32'(rsp_valid), 32'(0));
            chk($sformatf("rs_post_bready_%0d", i), 32'(M_AXI_BREADY), 32'(0));
        end
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = RESP_OKAY;

        // Normal operation resumes.
        run_vec(7, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4lite_cmd_master.md
Name: axi4lite_cmd_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple command stream (read/write, address, data, strobe) into AXI4-Lite master transactions.
- Returns each completion on a response stream.
- Drives the slave side of any register-mapped firmware block (its axi4lite interface top) from on-fabric sequencers, and serves as the bench-side driver in block-level simulation.
- Reports slave stalls through a timeout counter.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- C_M_AXI_ADDR_WIDTH, 11, AXI byte-address width.
- TIMEOUT_CYCLES, 1024, cycles waited per channel handshake before timeout is flagged; 0 disables the timeout.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESETN  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  completion present.
- rsp_ready  in  1  consumer accepts completion.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP as returned.
- timeout_flag  out  1  sticky; set when any handshake exceeds TIMEOUT_CYCLES.
- timeout_clr  in  1  synchronous clear of timeout_flag.
- M_AXI_AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY: standard AXI4-Lite master directions and widths.

Behaviour:
- Reset values:
  - All VALID/READY outputs 0; rsp_valid 0; timeout_flag 0.
  - Address, data and rsp_* registers 0; state IDLE.
  - Reset is asynchronous and acts mid-transaction: valids drop immediately and the in-flight command is lost with no response.
- AWPROT and ARPROT are constant 3'b000.
- Addresses are word-aligned: low log2(DATA_WIDTH/8) bits are forced to 0 on AWADDR/ARADDR.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register the command.
  - Write: next state WR_ADDR_DATA, with AWVALID and WVALID both 1 in the next cycle.
  - Read: next state RD_ADDR, with ARVALID 1 in the next cycle.
- WR_ADDR_DATA:
  - AWVALID and WVALID drop independently, in the cycle after their own handshake. Either order is legal, including the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BRESP, set rsp_rdata=0 and rsp_write=1, go to RESP.
- RD_ADDR: ARVALID held until ARREADY, then go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID, capture RDATA/RRESP, set rsp_write=0, go to RESP.
- RESP:
  - rsp_valid=1, rsp_* stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE.
  - A new command can be accepted no earlier than the cycle after the response handshake.
- AXI rules:
  - VALID never depends combinationally on READY.
  - Once asserted, a VALID and its payload are held stable until its handshake.
  - BREADY/RREADY are asserted only in WR_RESP/RD_DATA.
- Minimum latency, with the slave ready immediately: command accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, rsp_valid at cycle 3.
- Timeout:
  - The counter resets on each state entry and counts while in WR_ADDR_DATA, WR_RESP, RD_ADDR or RD_DATA.
  - When it reaches TIMEOUT_CYCLES, timeout_flag is set and the counter saturates.
  - The transaction is never abandoned; the AXI protocol is preserved.
  - timeout_clr in the same cycle as a set: the set wins.
- cmd_* changes while not in IDLE are ignored.

Decomposition:
- Shared package axi4lite_pkg:
  - Response codes RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR.
  - Enum axi_master_state_t.
  - Command and response struct typedefs, parameterised by width via the package's localparams for the default 32/11 case.
- One natural sub-module: axi4lite_timeout_ctr (saturating counter, restart, expire pulse).

Test Plan:
- Write addr 0x008, data 0xDEADBEEF, strb 0xF; slave ready immediately:
  - AW/W handshake at cycle 1, AWADDR=0x008.
  - rsp_valid at cycle 3, rsp_resp=00, rsp_write=1.
- Read addr 0x00D; slave returns RDATA=0x12345678 after 4 wait cycles:
  - ARADDR=0x00C.
  - rsp_rdata=0x12345678, rsp_resp=00, rsp_write=0.
- Write where WREADY comes 3 cycles before AWREADY:
  - WVALID drops after its handshake while AWVALID is still held.
  - Exactly one B accepted.
  - rsp_resp passes through SLVERR=10.
- Response backpressure: hold rsp_ready=0 for 5 cycles:
  - rsp_* stable and cmd_ready=0 throughout.
  - Next command accepted only after the handshake.
- TIMEOUT_CYCLES=16, ARREADY withheld for 20 cycles:
  - timeout_flag rises at cycle 16 of RD_ADDR.
  - The read still completes and the flag stays set until timeout_clr.
- Assert M_AXI_ARESETN low while in WR_RESP:
  - All valids/readies are 0 immediately.
  - After release, cmd_ready=1 and no spurious rsp_valid.
